wb_layer_sequencer: RTL and testbench
=====================================

// Module: wb_layer_sequencer
// PURPOSE
// - Per-layer sequencer for the weight/bias separator: holds a table of per-layer {source, bias, weight} lengths.
// - On start, walks layers 0..num_layers-1; for each layer it issues the 2-word config on the separator config
//   stream, then counts the separator's bias/weight output beats until the layer is fully drained.
// - Sits between the PS control registers and the separator; owns the separator config port exclusively.
// PARAMETERS
// - MAX_LAYERS  default 32  table depth; addr width = $clog2(MAX_LAYERS)
// - SRC_PS      default 1   value of word0[31] meaning "data from PS" (separator streams only in this case)
// PORTS
// - clk                     in   1    clock
// - rst                     in   1    async reset, active-high
// - tbl_wr_en               in   1    table write strobe (ignored while busy)
// - tbl_wr_addr             in   AW   layer index to write
// - tbl_wr_word0            in   32   {source[31], bias_len_raw[30:0]}
// - tbl_wr_word1            in   32   weight_len_raw
// - start                   in   1    1-cycle pulse; ignored while busy
// - num_layers              in   AW+1 layers to run, sampled on start; 0 -> immediate done
// - m_axis_wbconfig_tvalid  out  1    config word valid
// - m_axis_wbconfig_tready  in   1    separator ready
// - m_axis_wbconfig_tdata   out  32   config word
// - status_wbs              in   4    separator state (0 = IDLE)
// - mon_bias_fire           in   1    separator bias out valid&ready
// - mon_weight_fire         in   1    separator weight out valid&ready
// - busy                    out  1    high from accepted start to done
// - done                    out  1    1-cycle pulse at end of run
// - err                     out  1    sticky; cleared on next accepted start
// - layer_idx               out  AW   layer currently sequenced
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, counters 0; the table is not reset.
// - FSM: IDLE -> WAIT_SEP -> CFG0 -> CFG1 -> RUN -> NEXT -> (WAIT_SEP | FIN) -> IDLE.
// - IDLE: start & ~busy -> latch num_layers, clear err, layer_idx=0, busy=1; num_layers==0 -> FIN.
// - WAIT_SEP: hold until status_wbs==0 for 2 consecutive cycles, then read the table entry.
// - CFG0: tvalid=1, tdata=word0, held stable until tready. CFG1: same for word1. tvalid drops the cycle after the CFG1 handshake.
// - Expected beats: bias_exp = word0[30:0]>>2; wgt_exp = word1>>3 (32-bit unsigned, truncating).
// - source!=SRC_PS: separator does not stream; skip RUN, go to NEXT after the CFG1 handshake.
// - bias_exp==0 or wgt_exp==0 with source==SRC_PS: err=1; do not issue config; skip to NEXT.
//   (The separator would hang on a zero length.)
// - RUN: bias_cnt += mon_bias_fire; wgt_cnt += mon_weight_fire. Both may pulse in the same cycle; count both.
//   - Leave RUN when bias_cnt==bias_exp && wgt_cnt==wgt_exp (counter values after the update, same cycle).
//   - A weight beat before bias_cnt==bias_exp, or any count exceeding expected: err=1, keep counting.
// - NEXT: clear counters, layer_idx+1; last layer -> FIN, else WAIT_SEP.
// - FIN: done=1 for one cycle, busy=0, layer_idx holds its final value -> IDLE.
// - Monitor pulses outside RUN are ignored. tbl_wr_en while busy is dropped, and the table is unchanged.
// - Async reset mid-run: immediate return to IDLE, tvalid=0; a pending config word is abandoned.
// - Latency: start -> CFG0 tvalid = 4 cycles with the separator already idle.
// CONFIGURATION
// - WB_SEQ_TIMEOUT_EN defined:
//   - 24-bit watchdog resets on any mon fire or config handshake.
//   - Reaching 2^24-1 in WAIT_SEP, CFG0, CFG1 or RUN sets err=1 and forces FIN (done pulses, busy=0).
// - WB_SEQ_TIMEOUT_EN undefined: no watchdog logic; the FSM waits indefinitely.
// TESTING
// - Layer0: word0=0x8000_0040, word1=0x100, num_layers=1, start -> config words 0x8000_0040 then 0x100;
//   16 bias + 32 weight fires -> done, err=0.
// - 3 layers, tready toggled every other cycle, simultaneous fires allowed -> 6 config words in order;
//   layer_idx steps 0,1,2; one done pulse.
// - Layer with word0[31]=0 -> both config words sent, no RUN, NEXT immediately; monitor pulses ignored.
// - word1=0x4 (wgt_exp=0), PS source -> no config issued, err=1, run completes with done.
// - Weight fire while bias_cnt=3 of 16 -> err=1 set that cycle, layer still completes on full counts.
// - Reset asserted during CFG1 with tvalid high -> tvalid=0, busy=0 asynchronously;
//   new start after reset runs cleanly. With WB_SEQ_TIMEOUT_EN: stall RUN -> err and done after 2^24-1 cycles.

Source files
------------

// File: rtl/wb_layer_sequencer.sv
// Per-layer sequencer for the weight/bias separator: walks a length table, issues config words, counts beats.
// Optional watchdog enabled by defining WB_SEQ_TIMEOUT_EN.
module wb_layer_sequencer #(
  parameter int   MAX_LAYERS = 32,
  parameter logic SRC_PS     = 1'b1,
  localparam int  AW         = $clog2(MAX_LAYERS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tbl_wr_en,
  input  logic [AW-1:0] tbl_wr_addr,
  input  logic [31:0]   tbl_wr_word0,
  input  logic [31:0]   tbl_wr_word1,
  input  logic          start,
  input  logic [AW:0]   num_layers,
  output logic          m_axis_wbconfig_tvalid,
  input  logic          m_axis_wbconfig_tready,
  output logic [31:0]   m_axis_wbconfig_tdata,
  input  logic [3:0]    status_wbs,
  input  logic          mon_bias_fire,
  input  logic          mon_weight_fire,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] layer_idx
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_SEP = 3'd1,
    S_CFG0     = 3'd2,
    S_CFG1     = 3'd3,
    S_RUN      = 3'd4,
    S_NEXT     = 3'd5,
    S_FIN      = 3'd6
  } state_t;

  state_t        state_r, state_nxt_s, fsm_nxt_s;
  logic [31:0]   tbl_word0_r [MAX_LAYERS];
  logic [31:0]   tbl_word1_r [MAX_LAYERS];
  logic [31:0]   rd_word0_s, rd_word1_s, word1_r;
  logic [31:0]   bias_exp_r, wgt_exp_r, bias_cnt_r, wgt_cnt_r, bias_nxt_s, wgt_nxt_s;
  logic          src_r;
  logic [1:0]    idle_cnt_r;
  logic [AW:0]   num_r, layer_nxt_s;
  logic          accept_s, hs_s, load_s, rd_zero_s, run_err_s, set_err_s, last_layer_s;
  logic          run_full_s, timeout_s;

  assign rd_word0_s   = tbl_word0_r[layer_idx];
  assign rd_word1_s   = tbl_word1_r[layer_idx];
  assign accept_s     = (state_r == S_IDLE) && start && !busy;
  assign hs_s         = m_axis_wbconfig_tvalid && m_axis_wbconfig_tready;
  assign load_s       = (state_r == S_WAIT_SEP) && (idle_cnt_r == 2'd2);
  assign layer_nxt_s  = {1'b0, layer_idx} + {{AW{1'b0}}, 1'b1};
  assign last_layer_s = (layer_nxt_s == num_r);
  assign bias_nxt_s   = bias_cnt_r + {31'd0, mon_bias_fire};
  assign wgt_nxt_s    = wgt_cnt_r + {31'd0, mon_weight_fire};
  assign run_full_s   = (bias_nxt_s == bias_exp_r) && (wgt_nxt_s == wgt_exp_r);
  // A zero length on a PS-sourced layer would hang the separator, so it is never configured.
  assign rd_zero_s    = (rd_word0_s[31] == SRC_PS) &&
                        ((rd_word0_s[30:2] == 29'd0) || (rd_word1_s[31:3] == 29'd0));
  assign run_err_s    = (state_r == S_RUN) &&
                        ((mon_weight_fire && (bias_nxt_s < bias_exp_r)) ||
                         (bias_nxt_s > bias_exp_r) || (wgt_nxt_s > wgt_exp_r));
  assign set_err_s    = run_err_s || (load_s && rd_zero_s) || timeout_s;

`ifdef WB_SEQ_TIMEOUT_EN
  logic [23:0] wd_r;
  logic        wd_watch_s;
  assign wd_watch_s = (state_r == S_WAIT_SEP) || (state_r == S_CFG0) ||
                      (state_r == S_CFG1) || (state_r == S_RUN);
  assign timeout_s  = wd_watch_s && (wd_r == 24'hFF_FFFF);

  // Watchdog: restarts on any progress, counts only while waiting on the separator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_r <= 24'd0;
    end else if (!wd_watch_s || mon_bias_fire || mon_weight_fire || hs_s) begin
      wd_r <= 24'd0;
    end else begin
      wd_r <= wd_r + 24'd1;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state decode.
  always_comb begin
    fsm_nxt_s = state_r;
    case (state_r)
      S_IDLE:     fsm_nxt_s = accept_s ? ((num_layers == '0) ? S_FIN : S_WAIT_SEP) : S_IDLE;
      S_WAIT_SEP: fsm_nxt_s = load_s ? (rd_zero_s ? S_NEXT : S_CFG0) : S_WAIT_SEP;
      S_CFG0:     fsm_nxt_s = hs_s ? S_CFG1 : S_CFG0;
      S_CFG1:     fsm_nxt_s = hs_s ? ((src_r == SRC_PS) ? S_RUN : S_NEXT) : S_CFG1;
      S_RUN:      fsm_nxt_s = run_full_s ? S_NEXT : S_RUN;
      S_NEXT:     fsm_nxt_s = last_layer_s ? S_FIN : S_WAIT_SEP;
      S_FIN:      fsm_nxt_s = S_IDLE;
      default:    fsm_nxt_s = S_IDLE;
    endcase
    state_nxt_s = timeout_s ? S_FIN : fsm_nxt_s;
  end

  // Layer table; writes are dropped while a run is in progress.
  always_ff @(posedge clk) begin
    if (tbl_wr_en && !busy) begin
      tbl_word0_r[tbl_wr_addr] <= tbl_wr_word0;
      tbl_word1_r[tbl_wr_addr] <= tbl_wr_word1;
    end
  end

  // State, registered outputs, counters and latched layer entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r                <= S_IDLE;
      m_axis_wbconfig_tvalid <= 1'b0;
      m_axis_wbconfig_tdata  <= 32'd0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      err                    <= 1'b0;
      layer_idx              <= '0;
      num_r                  <= '0;
      idle_cnt_r             <= 2'd0;
      bias_cnt_r             <= 32'd0;
      wgt_cnt_r              <= 32'd0;
      bias_exp_r             <= 32'd0;
      wgt_exp_r              <= 32'd0;
      word1_r                <= 32'd0;
      src_r                  <= 1'b0;
    end else begin
      state_r                <= state_nxt_s;
      m_axis_wbconfig_tvalid <= (state_nxt_s == S_CFG0) || (state_nxt_s == S_CFG1);
      busy                   <= !((state_nxt_s == S_IDLE) || (state_nxt_s == S_FIN));
      done                   <= (state_nxt_s == S_FIN);
      if (accept_s) begin
        err       <= 1'b0;
        num_r     <= num_layers;
        layer_idx <= '0;
      end else begin
        if (set_err_s) err <= 1'b1;
        if ((state_r == S_NEXT) && !last_layer_s) layer_idx <= layer_nxt_s[AW-1:0];
      end
      // Separator must report idle on two consecutive cycles before the entry is read.
      if ((state_r == S_WAIT_SEP) && (status_wbs == 4'd0)) begin
        if (idle_cnt_r != 2'd2) idle_cnt_r <= idle_cnt_r + 2'd1;
      end else begin
        idle_cnt_r <= 2'd0;
      end
      if (load_s) begin
        src_r      <= rd_word0_s[31];
        bias_exp_r <= {3'b000, rd_word0_s[30:2]};
        wgt_exp_r  <= {3'b000, rd_word1_s[31:3]};
        word1_r    <= rd_word1_s;
      end
      if ((state_r == S_WAIT_SEP) && (state_nxt_s == S_CFG0)) begin
        m_axis_wbconfig_tdata <= rd_word0_s;
      end else if ((state_r == S_CFG0) && hs_s) begin
        m_axis_wbconfig_tdata <= word1_r;
      end
      if (state_r == S_RUN) begin
        bias_cnt_r <= bias_nxt_s;
        wgt_cnt_r  <= wgt_nxt_s;
      end else begin
        bias_cnt_r <= 32'd0;
        wgt_cnt_r  <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_wb_layer_sequencer.sv
// Directed bench for wb_layer_sequencer: config words are scoreboarded, run status checked per step.
module tb_wb_layer_sequencer;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          tbl_wr_en;
  logic [AW-1:0] tbl_wr_addr;
  logic [31:0]   tbl_wr_word0, tbl_wr_word1;
  logic          start;
  logic [AW:0]   num_layers;
  logic          tvalid, tready;
  logic [31:0]   tdata;
  logic [3:0]    status_wbs;
  logic          mon_bias_fire, mon_weight_fire;
  logic          busy, done, err;
  logic [AW-1:0] layer_idx;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int done_count = 0;
  logic [31:0] sb_q [$];

  wb_layer_sequencer dut (
    .clk(clk), .rst(rst),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr),
    .tbl_wr_word0(tbl_wr_word0), .tbl_wr_word1(tbl_wr_word1),
    .start(start), .num_layers(num_layers),
    .m_axis_wbconfig_tvalid(tvalid), .m_axis_wbconfig_tready(tready),
    .m_axis_wbconfig_tdata(tdata), .status_wbs(status_wbs),
    .mon_bias_fire(mon_bias_fire), .mon_weight_fire(mon_weight_fire),
    .busy(busy), .done(done), .err(err), .layer_idx(layer_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Config handshakes are compared against the scoreboard; done pulses are counted.
  always @(negedge clk) begin
    if (!rst && tvalid && tready) begin
      hs_count++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL cfg_unexpected observed=0x%08h expected=none", tdata);
      end else begin
        check("cfg_word", tdata, sb_q.pop_front());
      end
    end
    if (!rst && done) done_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_tbl(input logic [AW-1:0] a, input logic [31:0] w0, input logic [31:0] w1);
    tbl_wr_addr = a; tbl_wr_word0 = w0; tbl_wr_word1 = w1; tbl_wr_en = 1'b1;
    tick();
    tbl_wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [AW:0] n);
    num_layers = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_hs(input int target, input bit toggle);
    int n = 0;
    tready = 1'b1;
    while (hs_count < target && n < 300) begin
      tick();
      n++;
      if (toggle) tready = ~tready;
    end
    tready = 1'b1;
    check("hs_timeout", 32'(hs_count >= target), 32'd1);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_count < target && n < 1000) begin
      tick();
      n++;
    end
    check("done_timeout", 32'(done_count >= target), 32'd1);
  endtask

  task automatic feed(input int nb, input int nw, input bit sim, input bit gap);
    int w = nw;
    for (int i = 0; i < nb; i++) begin
      mon_bias_fire = 1'b1;
      mon_weight_fire = (sim && i == nb - 1 && w > 0);
      if (mon_weight_fire) w--;
      tick();
      mon_bias_fire = 1'b0; mon_weight_fire = 1'b0;
      if (gap) tick();
    end
    for (int i = 0; i < w; i++) begin
      mon_weight_fire = 1'b1;
      tick();
      mon_weight_fire = 1'b0;
      if (gap) tick();
    end
  endtask

  initial begin
    int base, dbase, lat;
    int nb3 [3];
    int nw3 [3];
    nb3 = '{4, 2, 3};
    nw3 = '{8, 4, 3};
    rst = 1'b1; tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_word0 = 32'd0; tbl_wr_word1 = 32'd0;
    start = 1'b0; num_layers = '0; tready = 1'b0; status_wbs = 4'd0;
    mon_bias_fire = 1'b0; mon_weight_fire = 1'b0;
    repeat (3) tick();
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_layer_idx", 32'(layer_idx), 32'd0);
    rst = 1'b0;
    tick();

    // Single layer: 16 bias and 32 weight beats.
    wr_tbl(5'd0, 32'h8000_0040, 32'h0000_0100);
    sb_q.push_back(32'h8000_0040); sb_q.push_back(32'h0000_0100);
    base = hs_count; dbase = done_count;
    pulse_start(6'd1);
    lat = 1;
    while (!tvalid && lat < 20) begin
      tick();
      lat++;
    end
    check("start_latency", 32'(lat), 32'd4);
    wait_hs(base + 2, 1'b0);
    check("l0_busy", 32'(busy), 32'd1);
    check("l0_layer_idx", 32'(layer_idx), 32'd0);
    feed(16, 32, 1'b0, 1'b0);
    wait_done(dbase + 1);
    check("l0_done_width", 32'(done), 32'd0);
    check("l0_err", 32'(err), 32'd0);
    check("l0_busy_end", 32'(busy), 32'd0);

    // Three layers, tready toggling, last bias beat coincident with first weight beat.
    for (int k = 0; k < 3; k++) begin
      wr_tbl(AW'(k), 32'h8000_0000 | 32'(nb3[k] << 2), 32'(nw3[k] << 3));
      sb_q.push_back(32'h8000_0000 | 32'(nb3[k] << 2));
      sb_q.push_back(32'(nw3[k] << 3));
    end
    base = hs_count; dbase = done_count;
    pulse_start(6'd3);
    for (int k = 0; k < 3; k++) begin
      wait_hs(base + 2 * (k + 1), 1'b1);
      check("ml_layer_idx", 32'(layer_idx), 32'(k));
      feed(nb3[k], nw3[k], 1'b1, 1'b1);
    end
    wait_done(dbase + 1);
    repeat (3) tick();
    check("ml_done_count", 32'(done_count - dbase), 32'd1);
    check("ml_layer_final", 32'(layer_idx), 32'd2);

    // Non-PS layer: both words sent, no RUN; monitor pulses and a busy separator held first.
    wr_tbl(5'd0, 32'h0000_0040, 32'h0000_0100);
    sb_q.push_back(32'h0000_0040); sb_q.push_back(32'h0000_0100);
    status_wbs = 4'd5; mon_bias_fire = 1'b1; mon_weight_fire = 1'b1;
    base = hs_count; dbase = done_count;
    pulse_start(6'd1);
    repeat (6) tick();
    check("wait_sep_hold", 32'(tvalid), 32'd0);
    status_wbs = 4'd0;
    wait_hs(base + 2, 1'b0);
    wait_done(dbase + 1);
    mon_bias_fire = 1'b0; mon_weight_fire = 1'b0;
    check("nonps_err", 32'(err), 32'd0);
    check("nonps_hs", 32'(hs_count - base), 32'd2);

    // Zero weight length on PS layer: no config, err set, run still finishes.
    wr_tbl(5'd0, 32'h8000_0040, 32'h0000_0004);
    base = hs_count; dbase = done_count;
    pulse_start(6'd1);
    wait_done(dbase + 1);
    check("zero_len_err", 32'(err), 32'd1);
    check("zero_len_no_cfg", 32'(hs_count - base), 32'd0);

    // Early weight beat flags err, layer still completes.
    wr_tbl(5'd0, 32'h8000_0040, 32'h0000_0100);
    sb_q.push_back(32'h8000_0040); sb_q.push_back(32'h0000_0100);
    base = hs_count; dbase = done_count;
    pulse_start(6'd1);
    check("err_cleared_on_start", 32'(err), 32'd0);
    wait_hs(base + 2, 1'b0);
    feed(3, 0, 1'b0, 1'b0);
    check("err_before_early", 32'(err), 32'd0);
    mon_weight_fire = 1'b1;
    tick();
    mon_weight_fire = 1'b0;
    check("err_early_weight", 32'(err), 32'd1);
    feed(13, 31, 1'b0, 1'b0);
    wait_done(dbase + 1);
    check("err_sticky", 32'(err), 32'd1);

    // Asynchronous reset while word1 is pending.
    sb_q.push_back(32'h8000_0040); sb_q.push_back(32'h0000_0100);
    base = hs_count;
    pulse_start(6'd1);
    wait_hs(base + 1, 1'b0);
    tready = 1'b0;
    check("cfg1_pending", 32'(tvalid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tvalid", 32'(tvalid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    sb_q.delete();
    tick();
    rst = 1'b0;
    tick();

    // Clean rerun from the retained table; a write while busy must be dropped.
    for (int r = 0; r < 2; r++) begin
      sb_q.push_back(32'h8000_0040); sb_q.push_back(32'h0000_0100);
      base = hs_count; dbase = done_count;
      pulse_start(6'd1);
      wait_hs(base + 2, 1'b0);
      if (r == 0) wr_tbl(5'd0, 32'h8000_0004, 32'h0000_0008);
      feed(16, 32, 1'b0, 1'b0);
      wait_done(dbase + 1);
      check("rerun_err", 32'(err), 32'd0);
    end

    // num_layers == 0 finishes at once with no config traffic.
    base = hs_count; dbase = done_count;
    pulse_start(6'd0);
    wait_done(dbase + 1);
    check("zero_layers_hs", 32'(hs_count - base), 32'd0);
    check("zero_layers_busy", 32'(busy), 32'd0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
